// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between the I-cache and D-cache.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is D-cache fixed priority.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic              i_req_valid,
   input  logic              i_req_wr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic [DATA_W-1:0] i_req_data,
   output logic              i_req_ready,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic              d_req_valid,
   input  logic              d_req_wr,
   input  logic [DATA_W-1:0] d_wr_data,
   output logic [DATA_W-1:0] d_req_data,
   output logic              d_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_req_valid,
   output logic              mem_req_wr,
   input  logic [DATA_W-1:0] mem_req_data,
   input  logic              mem_req_ready,
   output logic [1:0]        grant
);

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

   state_t r_state, w_next;
   logic   w_tie_d;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_d;
   // Last served was I (or nothing since reset), so D wins the tie.
   assign w_tie_d = ~r_last_d;
`else
   assign w_tie_d = 1'b1;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (i_req_valid && d_req_valid) w_next = w_tie_d ? GRANT_D : GRANT_I;
            else if (d_req_valid)           w_next = GRANT_D;
            else if (i_req_valid)           w_next = GRANT_I;
         end
         GRANT_I, GRANT_D: if (mem_req_ready) w_next = RELEASE;
         RELEASE:          w_next = IDLE;
         default:          w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         i_req_data    <= '0;
         i_req_ready   <= 1'b0;
         d_req_data    <= '0;
         d_req_ready   <= 1'b0;
         mem_req_addr  <= '0;
         mem_wr_data   <= '0;
         mem_req_valid <= 1'b0;
         mem_req_wr    <= 1'b0;
         grant         <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
         r_last_d      <= 1'b0;
`endif
      end else begin
         r_state     <= w_next;
         i_req_ready <= 1'b0;
         d_req_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               // Request is captured once on grant entry; later input changes are ignored.
               if (w_next == GRANT_I) begin
                  mem_req_addr  <= i_req_addr;
                  mem_req_wr    <= i_req_wr;
                  mem_wr_data   <= i_wr_data;
                  mem_req_valid <= 1'b1;
                  grant         <= 2'b01;
`ifdef ARB_ROUND_ROBIN_EN
                  r_last_d      <= 1'b0;
`endif
               end else if (w_next == GRANT_D) begin
                  mem_req_addr  <= d_req_addr;
                  mem_req_wr    <= d_req_wr;
                  mem_wr_data   <= d_wr_data;
                  mem_req_valid <= 1'b1;
                  grant         <= 2'b10;
`ifdef ARB_ROUND_ROBIN_EN
                  r_last_d      <= 1'b1;
`endif
               end
            end
            GRANT_I: begin
               if (mem_req_ready) begin
                  if (!mem_req_wr) i_req_data <= mem_req_data;
                  i_req_ready   <= 1'b1;
                  mem_req_valid <= 1'b0;
                  mem_req_wr    <= 1'b0;
                  grant         <= 2'b00;
               end
            end
            GRANT_D: begin
               if (mem_req_ready) begin
                  if (!mem_req_wr) d_req_data <= mem_req_data;
                  d_req_ready   <= 1'b1;
                  mem_req_valid <= 1'b0;
                  mem_req_wr    <= 1'b0;
                  grant         <= 2'b00;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (default fixed-priority build) with a completion scoreboard.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_req_addr, i_wr_data, i_req_data;
   logic        i_req_valid, i_req_wr, i_req_ready;
   logic [31:0] d_req_addr, d_wr_data, d_req_data;
   logic        d_req_valid, d_req_wr, d_req_ready;
   logic [31:0] mem_req_addr, mem_wr_data, mem_req_data;
   logic        mem_req_valid, mem_req_wr, mem_req_ready;
   logic [1:0]  grant;

   typedef struct {
      logic        is_d;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .i_req_addr(i_req_addr), .i_req_valid(i_req_valid), .i_req_wr(i_req_wr),
      .i_wr_data(i_wr_data), .i_req_data(i_req_data), .i_req_ready(i_req_ready),
      .d_req_addr(d_req_addr), .d_req_valid(d_req_valid), .d_req_wr(d_req_wr),
      .d_wr_data(d_wr_data), .d_req_data(d_req_data), .d_req_ready(d_req_ready),
      .mem_req_addr(mem_req_addr), .mem_wr_data(mem_wr_data),
      .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr),
      .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
      .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_grant"}, 32'(grant), 32'd0);
      check({tag, "_mvalid"}, 32'(mem_req_valid), 32'd0);
      check({tag, "_mwr"}, 32'(mem_req_wr), 32'd0);
      check({tag, "_iready"}, 32'(i_req_ready), 32'd0);
      check({tag, "_dready"}, 32'(d_req_ready), 32'd0);
   endtask

   // Completion monitor: every ready pulse must match the oldest outstanding expectation.
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (i_req_ready || d_req_ready) begin
         check("ready_onehot", 32'(i_req_ready & d_req_ready), 32'd0);
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL unexpected_ready got i=%b d=%b exp=none", i_req_ready, d_req_ready);
         end else begin
            e = sb.pop_front();
            check("sb_owner_d", 32'(d_req_ready), 32'(e.is_d));
            check("sb_data", e.is_d ? d_req_data : i_req_data, e.data);
         end
      end
   end

   initial begin
      rst = 1'b1;
      i_req_addr = '0; i_req_valid = 0; i_req_wr = 0; i_wr_data = '0;
      d_req_addr = '0; d_req_valid = 0; d_req_wr = 0; d_wr_data = '0;
      mem_req_data = '0; mem_req_ready = 0;
      tick(2);
      check_idle_outputs("reset");
      check("reset_mem_addr", mem_req_addr, 32'd0);
      check("reset_idata", i_req_data, 32'd0);
      check("reset_ddata", d_req_data, 32'd0);
      rst = 1'b0;
      tick();

      // I-only read, memory ready in cycle 3
      i_req_addr = 32'h40; i_req_valid = 1; i_req_wr = 0;
      sb.push_back('{1'b0, 32'hDEAD_BEEF});
      tick();                                             // cycle 1
      check("t1_c1_grant", 32'(grant), 32'd1);
      check("t1_c1_mvalid", 32'(mem_req_valid), 32'd1);
      check("t1_c1_addr", mem_req_addr, 32'h40);
      check("t1_c1_mwr", 32'(mem_req_wr), 32'd0);
      tick();                                             // cycle 2
      check("t1_c2_mvalid", 32'(mem_req_valid), 32'd1);
      check("t1_c2_iready", 32'(i_req_ready), 32'd0);
      tick();                                             // cycle 3
      check("t1_c3_mvalid", 32'(mem_req_valid), 32'd1);
      mem_req_ready = 1; mem_req_data = 32'hDEAD_BEEF;
      tick();                                             // cycle 4: RELEASE
      check("t1_c4_iready", 32'(i_req_ready), 32'd1);
      check("t1_c4_idata", i_req_data, 32'hDEAD_BEEF);
      check("t1_c4_mvalid", 32'(mem_req_valid), 32'd0);
      check("t1_c4_grant", 32'(grant), 32'd0);
      mem_req_ready = 0; i_req_valid = 0;
      tick();                                             // cycle 5: IDLE
      check_idle_outputs("t1_c5");
      tick();

      // D-only write
      d_req_addr = 32'h100; d_wr_data = 32'h1234_5678; d_req_wr = 1; d_req_valid = 1;
      sb.push_back('{1'b1, 32'h0});
      tick();
      check("t2_grant", 32'(grant), 32'd2);
      check("t2_mwr", 32'(mem_req_wr), 32'd1);
      check("t2_addr", mem_req_addr, 32'h100);
      check("t2_wdata", mem_wr_data, 32'h1234_5678);
      tick();
      check("t2_hold_mwr", 32'(mem_req_wr), 32'd1);
      check("t2_hold_wdata", mem_wr_data, 32'h1234_5678);
      mem_req_ready = 1; mem_req_data = 32'hFFFF_FFFF;
      tick();
      check("t2_dready", 32'(d_req_ready), 32'd1);
      check("t2_ddata", d_req_data, 32'h0);
      check("t2_mwr_clr", 32'(mem_req_wr), 32'd0);
      mem_req_ready = 0; d_req_valid = 0; d_req_wr = 0;
      tick();
      check_idle_outputs("t2_idle");
      tick();

      // Both valid in the same IDLE cycle: D first, I at k+3
      i_req_addr = 32'h200; i_req_wr = 0; i_req_valid = 1;
      d_req_addr = 32'h300; d_req_wr = 0; d_req_valid = 1;
      sb.push_back('{1'b1, 32'hAAAA_0001});
      sb.push_back('{1'b0, 32'hBBBB_0002});
      tick();                                             // cycle 1
      check("t3_first_grant", 32'(grant), 32'd2);
      check("t3_first_addr", mem_req_addr, 32'h300);
      mem_req_ready = 1; mem_req_data = 32'hAAAA_0001;
      tick();                                             // cycle 2: RELEASE
      mem_req_ready = 0; d_req_valid = 0;
      tick();                                             // cycle 3: IDLE
      check("t3_gap_grant", 32'(grant), 32'd0);
      tick();                                             // cycle 4
      check("t3_second_grant", 32'(grant), 32'd1);
      check("t3_second_addr", mem_req_addr, 32'h200);
      mem_req_ready = 1; mem_req_data = 32'hBBBB_0002;
      tick();
      mem_req_ready = 0; i_req_valid = 0;
      tick();
      check_idle_outputs("t3_idle");

      // Second simultaneous pair: fixed priority serves D first again
      i_req_addr = 32'h210; i_req_valid = 1;
      d_req_addr = 32'h310; d_req_valid = 1;
      sb.push_back('{1'b1, 32'hCCCC_0003});
      sb.push_back('{1'b0, 32'hDDDD_0004});
      tick();
      check("t3b_first_grant", 32'(grant), 32'd2);
      mem_req_ready = 1; mem_req_data = 32'hCCCC_0003;
      tick();
      mem_req_ready = 0; d_req_valid = 0;
      tick(2);
      check("t3b_second_grant", 32'(grant), 32'd1);
      check("t3b_second_addr", mem_req_addr, 32'h210);
      mem_req_ready = 1; mem_req_data = 32'hDDDD_0004;
      tick();
      mem_req_ready = 0; i_req_valid = 0;
      tick(2);

      // Requester inputs change mid-grant and are ignored
      i_req_addr = 32'h40; i_req_wr = 0; i_req_valid = 1;
      sb.push_back('{1'b0, 32'h0000_0055});
      tick();
      check("t4_c1_addr", mem_req_addr, 32'h40);
      i_req_addr = 32'h80; i_req_wr = 1;
      tick();
      check("t4_c2_addr", mem_req_addr, 32'h40);
      check("t4_c2_mwr", 32'(mem_req_wr), 32'd0);
      mem_req_ready = 1; mem_req_data = 32'h0000_0055;
      tick();
      mem_req_ready = 0; i_req_valid = 0; i_req_wr = 0;
      tick(2);

      // Reset mid-grant with memory stalled: no ready pulse
      d_req_addr = 32'h500; d_req_wr = 1; d_wr_data = 32'h7777_7777; d_req_valid = 1;
      tick();
      check("t5_grant", 32'(grant), 32'd2);
      check("t5_mwr", 32'(mem_req_wr), 32'd1);
      tick();
      rst = 1;
      tick();
      check_idle_outputs("t5_rst");
      check("t5_rst_addr", mem_req_addr, 32'd0);
      check("t5_rst_wdata", mem_wr_data, 32'd0);
      check("t5_rst_ddata", d_req_data, 32'd0);
      check("t5_rst_idata", i_req_data, 32'd0);
      rst = 0; d_req_valid = 0; d_req_wr = 0;
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      tick(2);
      check_idle_outputs("t5_after");

      // Stray mem_req_ready in IDLE with no requests
      mem_req_ready = 1; mem_req_data = 32'h9999_9999;
      tick();
      check_idle_outputs("t6_a");
      mem_req_ready = 0;
      tick();
      check_idle_outputs("t6_b");
      check("t6_idata", i_req_data, 32'd0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
